final_soc_pio_in_db: RTL and testbench

//  Parametrised Avalon-MM input PIO; next generation of the switch/key input port in final_soc.

---
 rtl/final_soc_pio_in_db_pkg.sv | 25 ++
 rtl/final_soc_pio_in_db_debounce_ch.sv | 61 ++++++
 rtl/final_soc_pio_in_db.sv | 89 ++++++++
 tb/tb_final_soc_pio_in_db.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/final_soc_pio_in_db_pkg.sv
// Shared constants for the final_soc debounced input PIO: register addresses,
// edge-capture modes and the edge-select helper.
package final_soc_pio_in_db_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RAW  = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_mode_e;

   // Unknown encodings fall back to capturing both edges.
   function automatic logic edge_hit(input edge_mode_e mode, input logic rise, input logic fall);
      case (mode)
         EDGE_RISE: edge_hit = rise;
         EDGE_FALL: edge_hit = fall;
         default:   edge_hit = rise | fall;
      endcase
   endfunction

endpackage

// File: rtl/final_soc_pio_in_db_debounce_ch.sv
// One input channel: multi-flop synchroniser, consecutive-mismatch counter,
// debounced stable bit and single-cycle rise/fall pulses on each accepted change.
module final_soc_debounce_ch #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic sync_out,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic                   commit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // cnt holds the number of mismatch cycles already seen; the N-th one commits.
   always_comb begin
      commit  = 1'b0;
      cnt_nxt = cnt;
      if (sync_out == stable) begin
         cnt_nxt = '0;
      end else if (cnt >= CNT_LAST) begin
         commit  = 1'b1;
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         stable <= stable ^ commit;
         cnt    <= cnt_nxt;
      end
   end

   assign rise = commit & sync_out;
   assign fall = commit & ~sync_out;

endmodule

// File: rtl/final_soc_pio_in_db.sv
// Avalon-MM input PIO with per-channel debounce, write-1-to-clear edge capture
// and a registered level interrupt for the Nios II.
module final_soc_pio_in_db
   import final_soc_pio_in_db_pkg::*;
#(
   parameter int unsigned WIDTH           = 10,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned EDGE_MODE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

   logic [WIDTH-1:0] sync_v;
   logic [WIDTH-1:0] stable_v;
   logic [WIDTH-1:0] rise_v;
   logic [WIDTH-1:0] fall_v;
   logic [WIDTH-1:0] edge_set;
   logic [WIDTH-1:0] wr_clr;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [31:0]      rd_nxt;
   logic             wr_en;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      final_soc_debounce_ch #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .din      (in_port[i]),
         .sync_out (sync_v[i]),
         .stable   (stable_v[i]),
         .rise     (rise_v[i]),
         .fall     (fall_v[i])
      );
      assign edge_set[i] = edge_hit(MODE, rise_v[i], fall_v[i]);
   end

   assign wr_en        = chipselect & ~write_n;
   assign unused_wdata = ^writedata;

   always_comb begin
      wr_clr = '0;
      if (wr_en && (address == ADDR_EDGE)) begin
         wr_clr = writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_nxt = '0;
      case (address)
         ADDR_DATA: rd_nxt[WIDTH-1:0] = stable_v;
         ADDR_RAW:  rd_nxt[WIDTH-1:0] = sync_v;
         ADDR_MASK: rd_nxt[WIDTH-1:0] = irq_mask;
         default:   rd_nxt[WIDTH-1:0] = edge_cap;
      endcase
   end

   // Set is OR'd in after the clear so a same-cycle capture survives W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
         readdata <= '0;
         irq      <= 1'b0;
      end else begin
         if (wr_en && (address == ADDR_MASK)) begin
            irq_mask <= writedata[WIDTH-1:0];
         end
         edge_cap <= (edge_cap & ~wr_clr) | edge_set;
         readdata <= rd_nxt;
         irq      <= |(edge_cap & irq_mask);
      end
   end

endmodule

// File: tb/tb_final_soc_pio_in_db.sv
// Bench for final_soc_pio_in_db: rising- and falling-capture instances share
// one bus and input, checked every cycle against a window-based reference.
module tb_final_soc_pio_in_db;

   localparam int W    = 10;
   localparam int SYNC = 2;
   localparam int DB   = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   readdata0, readdata1;
   logic          irq0, irq1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   final_soc_pio_in_db #(
      .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(0)
   ) dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata0), .irq(irq0)
   );

   final_soc_pio_in_db #(
      .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .EDGE_MODE(1)
   ) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata1), .irq(irq1)
   );

   // Reference: synced value is in_port delayed SYNC-1 edges after capture;
   // a stable bit flips once its last DB synced samples all disagreed with it.
   logic [W-1:0] in_hist[$];
   logic [W-1:0] raw_hist[$];
   logic [W-1:0] m_stable, m_mask;
   logic [W-1:0] m_ecap[2];
   logic [31:0]  m_rd[2];
   logic         m_irq[2];

   function automatic void model_reset();
      in_hist.delete();
      raw_hist.delete();
      for (int j = 0; j < SYNC - 1; j++) in_hist.push_back('0);
      for (int j = 0; j < DB; j++) raw_hist.push_back('0);
      m_stable = '0;
      m_mask   = '0;
      for (int k = 0; k < 2; k++) begin
         m_ecap[k] = '0;
         m_rd[k]   = '0;
         m_irq[k]  = 1'b0;
      end
   endfunction

   function automatic void model_step();
      logic [W-1:0] raw_now, mism, rise, fall, clr;
      logic         wr;
      raw_now = raw_hist[$];
      wr      = chipselect && !write_n;
      for (int k = 0; k < 2; k++) begin
         case (address)
            2'd0:    m_rd[k] = {22'b0, m_stable};
            2'd1:    m_rd[k] = {22'b0, raw_now};
            2'd2:    m_rd[k] = {22'b0, m_mask};
            default: m_rd[k] = {22'b0, m_ecap[k]};
         endcase
         m_irq[k] = |(m_ecap[k] & m_mask);
      end
      mism = '1;
      foreach (raw_hist[j]) mism &= raw_hist[j] ^ m_stable;
      rise     = mism & ~m_stable;
      fall     = mism & m_stable;
      m_stable = m_stable ^ mism;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      m_ecap[0] = (m_ecap[0] & ~clr) | rise;
      m_ecap[1] = (m_ecap[1] & ~clr) | fall;
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      in_hist.push_back(in_port);
      raw_hist.push_back(in_hist.pop_front());
      void'(raw_hist.pop_front());
   endfunction

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else          model_step();
      end
   end

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         checks++;
         if ({readdata0, irq0} !== {m_rd[0], m_irq[0]}) begin
            errors++;
            $display("FAIL cmp_rise t=%0t readdata=%h irq=%b expected readdata=%h irq=%b",
                     $time, readdata0, irq0, m_rd[0], m_irq[0]);
         end
         checks++;
         if ({readdata1, irq1} !== {m_rd[1], m_irq[1]}) begin
            errors++;
            $display("FAIL cmp_fall t=%0t readdata=%h irq=%b expected readdata=%h irq=%b",
                     $time, readdata1, irq1, m_rd[1], m_irq[1]);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 10'h3FF;
      tick(3);
      chk("rst_rd_rise", readdata0, 32'h0);
      chk("rst_irq_rise", {31'b0, irq0}, 32'h0);
      chk("rst_rd_fall", readdata1, 32'h0);
      chk("rst_irq_fall", {31'b0, irq1}, 32'h0);

      // Inputs high at reset: stable appears at 2+4, visible on readdata at +7.
      reset_n = 1'b1;
      tick(6);
      chk("rst_db_before", readdata0, 32'h0);
      tick(1);
      chk("rst_db_after", readdata0, 32'h3FF);
      address = 2'd3;
      tick(1);
      chk("rst_ecap_rise", readdata0, 32'h3FF);
      chk("rst_ecap_fall", readdata1, 32'h0);
      in_port = '0;
      tick(8);
      bus_wr(2'd3, 32'h3FF);
      tick(1);
      chk("init_clr_rise", readdata0, 32'h0);
      chk("init_clr_fall", readdata1, 32'h0);

      // Glitches: 3-cycle pulse rejected, 4-cycle pulse accepted.
      address    = 2'd0;
      in_port[0] = 1'b1;
      tick(3);
      in_port[0] = 1'b0;
      tick(8);
      chk("glitch_data", readdata0, 32'h0);
      address = 2'd3;
      tick(1);
      chk("glitch_ecap", readdata0, 32'h0);
      address    = 2'd0;
      in_port[0] = 1'b1;
      tick(4);
      in_port[0] = 1'b0;
      tick(3);
      chk("pulse_data", readdata0, 32'h1);
      tick(6);
      address = 2'd3;
      tick(1);
      chk("pulse_ecap", readdata0, 32'h1);
      bus_wr(2'd3, 32'h3FF);

      // IRQ assert one cycle after capture, deassert one cycle after clear.
      bus_wr(2'd2, 32'h1);
      in_port[0] = 1'b1;
      tick(6);
      chk("irq_pre", {31'b0, irq0}, 32'h0);
      tick(1);
      chk("irq_rise", {31'b0, irq0}, 32'h1);
      chk("irq_fallmode", {31'b0, irq1}, 32'h0);
      bus_wr(2'd3, 32'h1);
      chk("irq_hold", {31'b0, irq0}, 32'h1);
      tick(1);
      chk("irq_clear", {31'b0, irq0}, 32'h0);
      chk("ecap_clear", readdata0, 32'h0);

      // W1C lands in the same cycle stable[2] rises: capture wins.
      in_port[2] = 1'b1;
      tick(5);
      bus_wr(2'd3, 32'h4);
      tick(1);
      chk("w1c_race", readdata0, 32'h4);

      // Falling-edge instance: rise ignored, fall captured, mask=0 keeps irq low.
      bus_wr(2'd2, 32'h0);
      bus_wr(2'd3, 32'h3FF);
      in_port[5] = 1'b1;
      tick(8);
      address = 2'd3;
      tick(1);
      chk("fmode_rise", readdata1, 32'h0);
      in_port[5] = 1'b0;
      tick(8);
      chk("fmode_fall", readdata1, 32'h20);
      chk("fmode_irq", {31'b0, irq1}, 32'h0);

      // Reset two mismatch cycles into a debounce: count must restart.
      in_port[7] = 1'b1;
      tick(4);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      address = 2'd0;
      tick(6);
      chk("midrst_before", readdata0, 32'h0);
      tick(1);
      chk("midrst_after", readdata0, 32'h85);

      for (int c = 0; c < 3000; c++) begin
         int r;
         if ($urandom_range(0, 5) == 0) in_port ^= 10'(1 << $urandom_range(0, 9));
         r         = int'($urandom_range(0, 9));
         address   = 2'($urandom_range(0, 3));
         writedata = $urandom;
         chipselect = (r < 3);
         write_n    = !(r < 2 || r == 3);
         tick(1);
      end
      chipselect = 1'b0;
      write_n    = 1'b1;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
